lcd_ctrl_param: RTL and testbench

- Parametrised image-processing controller for the LCD path.
- Loads an IMG_W x IMG_H frame of DW-bit pixels from the image ROM into an internal buffer.
- Applies host commands to a 2x2 operation window, then streams the frame to the image RAM.
- Unlike the fixed 8x8 generation, it returns to command-accept after each write-out, so multiple frames can be written per reset, and it supports a frame reload command.

---
 rtl/lcd_ctrl_param.sv | 193 +++++++++++++++++++
 tb/tb_lcd_ctrl_param.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl_param.sv
// rtl/lcd_ctrl_param.sv - parametrised LCD image controller: ROM load, 2x2 window ops, RAM write-out
//
// Loads an IMG_W x IMG_H frame from the image ROM, applies host commands to a
// 2x2 window, and streams the frame to the image RAM. It returns to command
// accept after each write-out and accepts a reload command (0xC).
//
// Optional build macro: LCD_CTRL_ROUND_AVG_EN
//   defined   -> Average writes (sum+2)>>2 (round half up)
//   undefined -> Average writes sum>>2 (truncate)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   cmd        in   [3:0] command code, sampled when cmd_valid=1 and busy=0
//   cmd_valid  in   command strobe
//   IROM_Q     in   [DW-1:0] ROM data, valid the cycle after the address
//   IROM_rd    out  ROM read enable
//   IROM_A     out  [AW-1:0] ROM address
//   IRAM_valid out  RAM write strobe
//   IRAM_D     out  [DW-1:0] RAM write data
//   IRAM_A     out  [AW-1:0] RAM write address
//   busy       out  controller not accepting commands
//   done       out  one-cycle pulse after the last write of a frame

module lcd_ctrl_param #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [XW-1:0] X_INIT = XW'(IMG_W / 2 - 1);
    localparam logic [YW-1:0] Y_INIT = YW'(IMG_H / 2 - 1);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 2);
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);

`ifdef LCD_CTRL_ROUND_AVG_EN
    localparam logic [DW+1:0] AVG_RND = (DW+2)'(2);
`else
    localparam logic [DW+1:0] AVG_RND = '0;
`endif

    logic [DW-1:0] pix [N];
    logic [2:0]    state;
    logic [3:0]    cmd_r;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          ld_pend;
    logic [AW-1:0] ld_addr;

    // Widths are powers of two, so y*IMG_W + x is a plain concatenation.
    logic [AW-1:0] a0, a1, a2, a3;
    assign a0 = {y, x};
    assign a1 = {y, x + XW'(1)};
    assign a2 = {y + YW'(1), x};
    assign a3 = {y + YW'(1), x + XW'(1)};

    logic [DW-1:0] p0, p1, p2, p3;
    assign p0 = pix[a0];
    assign p1 = pix[a1];
    assign p2 = pix[a2];
    assign p3 = pix[a3];

    logic [DW-1:0] mx01, mx23, mx, mn01, mn23, mn, avg;
    logic [DW+1:0] sum;
    assign mx01 = (p0 > p1) ? p0 : p1;
    assign mx23 = (p2 > p3) ? p2 : p3;
    assign mx   = (mx01 > mx23) ? mx01 : mx23;
    assign mn01 = (p0 < p1) ? p0 : p1;
    assign mn23 = (p2 < p3) ? p2 : p3;
    assign mn   = (mn01 < mn23) ? mn01 : mn23;
    assign sum  = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    assign avg  = DW'((sum + AVG_RND) >> 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_LOAD;
            cmd_r      <= '0;
            x          <= X_INIT;
            y          <= Y_INIT;
            ld_pend    <= 1'b0;
            ld_addr    <= '0;
            IROM_rd    <= 1'b0;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_D     <= '0;
            IRAM_A     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            for (int i = 0; i < N; i++) pix[i] <= '0;
        end else begin
            // ROM data lands one cycle after its address; ld_pend tracks that slot.
            ld_pend <= 1'b0;
            if (ld_pend) pix[ld_addr] <= IROM_Q;

            case (state)
                S_LOAD: begin
                    ld_pend <= IROM_rd;
                    ld_addr <= IROM_A;
                    if (IROM_rd) begin
                        if (IROM_A == A_LAST) IROM_rd <= 1'b0;
                        else                  IROM_A  <= IROM_A + AW'(1);
                    end else if (ld_pend) begin
                        // last pixel is captured on this edge
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        IROM_rd <= 1'b1;
                        IROM_A  <= '0;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        busy  <= 1'b1;
                        cmd_r <= cmd;
                        if (cmd == 4'h0) begin
                            state <= S_WRITE;
                        end else if (cmd == 4'hC) begin
                            state <= S_LOAD;
                            x     <= X_INIT;
                            y     <= Y_INIT;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    case (cmd_r)
                        4'h1: if (y != '0)    y <= y - YW'(1);
                        4'h2: if (y != Y_MAX) y <= y + YW'(1);
                        4'h3: if (x != '0)    x <= x - XW'(1);
                        4'h4: if (x != X_MAX) x <= x + XW'(1);
                        4'h5: begin pix[a0] <= mx;  pix[a1] <= mx;  pix[a2] <= mx;  pix[a3] <= mx;  end
                        4'h6: begin pix[a0] <= mn;  pix[a1] <= mn;  pix[a2] <= mn;  pix[a3] <= mn;  end
                        4'h7: begin pix[a0] <= avg; pix[a1] <= avg; pix[a2] <= avg; pix[a3] <= avg; end
                        4'h8: begin pix[a0] <= p1;  pix[a1] <= p3;  pix[a2] <= p0;  pix[a3] <= p2;  end
                        4'h9: begin pix[a0] <= p2;  pix[a1] <= p0;  pix[a2] <= p3;  pix[a3] <= p1;  end
                        4'hA: begin pix[a0] <= p2;  pix[a1] <= p3;  pix[a2] <= p0;  pix[a3] <= p1;  end
                        4'hB: begin pix[a0] <= p1;  pix[a1] <= p0;  pix[a2] <= p3;  pix[a3] <= p2;  end
                        default: ;
                    endcase
                end
                S_WRITE: begin
                    if (!IRAM_valid) begin
                        IRAM_valid <= 1'b1;
                        IRAM_A     <= '0;
                        IRAM_D     <= pix[0];
                    end else if (IRAM_A == A_LAST) begin
                        IRAM_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        IRAM_A <= IRAM_A + AW'(1);
                        IRAM_D <= pix[IRAM_A + AW'(1)];
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb/tb_lcd_ctrl_param.sv - directed self-checking bench for lcd_ctrl_param

module tb_lcd_ctrl_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] cmd = 4'h0;
    logic       cv  = 1'b0;
    int         sel = 0;
    wire        cv1 = cv & (sel == 0);
    wire        cv2 = cv & (sel == 1);

    logic       irom_rd1, iram_v1, busy1, done1;
    logic [5:0] irom_a1, iram_a1;
    logic [7:0] irom_q1 = '0, iram_d1;
    logic       irom_rd2, iram_v2, busy2, done2;
    logic [5:0] irom_a2, iram_a2;
    logic [9:0] irom_q2 = '0, iram_d2;

    lcd_ctrl_param dut1 (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cv1), .IROM_Q(irom_q1),
        .IROM_rd(irom_rd1), .IROM_A(irom_a1), .IRAM_valid(iram_v1), .IRAM_D(iram_d1),
        .IRAM_A(iram_a1), .busy(busy1), .done(done1)
    );

    lcd_ctrl_param #(.DW(10), .IMG_W(16), .IMG_H(4), .AW(6)) dut2 (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cv2), .IROM_Q(irom_q2),
        .IROM_rd(irom_rd2), .IROM_A(irom_a2), .IRAM_valid(iram_v2), .IRAM_D(iram_d2),
        .IRAM_A(iram_a2), .busy(busy2), .done(done2)
    );

    int rom1 [64];
    int rom2 [64];
    int ram1 [64];
    int ram2 [64];
    int exp_f [64];
    int wr_cnt [2];
    int done_cnt [2];
    int seq_err [2];
    int last_a [2];
    int n_tests = 0;
    int n_fail = 0;

    always @(posedge clk) begin
        if (irom_rd1) irom_q1 <= 8'(rom1[irom_a1]);
        if (irom_rd2) irom_q2 <= 10'(rom2[irom_a2]);
    end

    always @(posedge clk) begin
        if (iram_v1) begin
            if (iram_a1 != 6'd0 && int'(iram_a1) != last_a[0] + 1) seq_err[0]++;
            last_a[0] = int'(iram_a1);
            ram1[iram_a1] = int'(iram_d1);
            wr_cnt[0]++;
        end
        if (done1) done_cnt[0]++;
        if (iram_v2) begin
            if (iram_a2 != 6'd0 && int'(iram_a2) != last_a[1] + 1) seq_err[1]++;
            last_a[1] = int'(iram_a2);
            ram2[iram_a2] = int'(iram_d2);
            wr_cnt[1]++;
        end
        if (done2) done_cnt[1]++;
    end

    task automatic check(input string tag, input int got, input int expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic logic busy_now();
        return (sel == 0) ? busy1 : busy2;
    endfunction

    function automatic logic done_now();
        return (sel == 0) ? done1 : done2;
    endfunction

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy_now() && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({tag, " idle"}, int'(busy_now()), 0);
    endtask

    // returns the number of busy cycles seen after the sampling edge
    task automatic send(input logic [3:0] c, output int nb);
        wait_idle("send");
        cmd = c;
        cv  = 1'b1;
        @(negedge clk);
        cv  = 1'b0;
        cmd = 4'h0;
        nb  = 0;
        while (busy_now() && nb < 400) begin
            @(negedge clk);
            nb++;
        end
    endtask

    task automatic send_n(input logic [3:0] c, input int n);
        int nb;
        for (int i = 0; i < n; i++) send(c, nb);
    endtask

    task automatic do_write(input string tag, input bit poke);
        int d0, w0, t;
        d0 = done_cnt[sel];
        w0 = wr_cnt[sel];
        wait_idle(tag);
        cmd = 4'h0;
        cv  = 1'b1;
        @(negedge clk);
        cv = 1'b0;
        t  = 0;
        while (!done_now() && t < 300) begin
            if (poke && t == 10) begin
                cmd = 4'h5;
                cv  = 1'b1;
            end else begin
                cv  = 1'b0;
                cmd = 4'h0;
            end
            @(negedge clk);
            t++;
        end
        cv  = 1'b0;
        cmd = 4'h0;
        check({tag, " done seen"}, int'(done_now()), 1);
        check({tag, " busy in done"}, int'(busy_now()), 1);
        @(negedge clk);
        check({tag, " busy after done"}, int'(busy_now()), 0);
        check({tag, " done pulses"}, done_cnt[sel] - d0, 1);
        check({tag, " writes"}, wr_cnt[sel] - w0, 64);
    endtask

    task automatic load_exp();
        for (int i = 0; i < 64; i++) exp_f[i] = (sel == 0) ? rom1[i] : rom2[i];
    endtask

    task automatic set_win(input int a, input int b, input int c, input int d,
                           input int v0, input int v1, input int v2, input int v3);
        exp_f[a] = v0; exp_f[b] = v1; exp_f[c] = v2; exp_f[d] = v3;
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < 64; i++)
            check($sformatf("%s px%0d", tag, i), (sel == 0) ? ram1[i] : ram2[i], exp_f[i]);
    endtask

    initial begin
        int t, rd, gap, nb, avg_exp;
        logic seen_fall;
`ifdef LCD_CTRL_ROUND_AVG_EN
        avg_exp = 59;
`else
        avg_exp = 58;
`endif
        for (int i = 0; i < 64; i++) begin
            rom1[i] = i;
            rom2[i] = i + 512;
        end

        // reset state
        repeat (3) @(negedge clk);
        check("rst IROM_rd", int'(irom_rd1), 0);
        check("rst IROM_A", int'(irom_a1), 0);
        check("rst busy", int'(busy1), 1);
        check("rst IRAM_valid", int'(iram_v1), 0);
        check("rst IRAM_D", int'(iram_d1), 0);
        check("rst done", int'(done1), 0);
        reset = 1'b0;

        // initial load, with a command pulsed mid-load that must be dropped
        t = 0; rd = 0; gap = 0; seen_fall = 1'b0;
        while (busy1 && t < 200) begin
            if (irom_rd1) rd++;
            else if (rd == 64) gap++;
            cv  = (t == 10);
            cmd = (t == 10) ? 4'h5 : 4'h0;
            @(negedge clk);
            t++;
        end
        cv = 1'b0;
        check("load busy fell", int'(busy1), 0);
        check("load rom reads", rd, 64);
        check("load capture tail", gap, 1);

        // write-out of the raw ROM image, poking Max during WRITE
        do_write("w1", 1'b1);
        load_exp();
        check_frame("frame0");
        do_write("w2", 1'b0);
        check_frame("frame0 again");

        // down x7 stops at y=6, left x5 stops at x=0, then Max
        send_n(4'h2, 7);
        send_n(4'h3, 5);
        send(4'h5, nb);
        check("exec busy cycles", nb, 1);
        do_write("w max corner", 1'b0);
        set_win(48, 49, 56, 57, 57, 57, 57, 57);
        check_frame("max corner");

        // reload restores image and origin 27
        send(4'hC, nb);
        send(4'h5, nb);
        do_write("w reload", 1'b0);
        load_exp();
        set_win(27, 28, 35, 36, 36, 36, 36, 36);
        check_frame("reload max");

        // average on 10,11 / 13,200
        rom1[27] = 10; rom1[28] = 11; rom1[35] = 13; rom1[36] = 200;
        send(4'hC, nb);
        send(4'h7, nb);
        do_write("w avg", 1'b0);
        load_exp();
        set_win(27, 28, 35, 36, avg_exp, avg_exp, avg_exp, avg_exp);
        check_frame("avg");

        // permutations on 1,2 / 3,4
        rom1[27] = 1; rom1[28] = 2; rom1[35] = 3; rom1[36] = 4;
        send(4'hC, nb);
        send(4'h9, nb);
        do_write("w cw", 1'b0);
        load_exp();
        set_win(27, 28, 35, 36, 3, 1, 4, 2);
        check_frame("cw");
        send_n(4'h9, 3);
        do_write("w cw4", 1'b0);
        set_win(27, 28, 35, 36, 1, 2, 3, 4);
        check_frame("cw x4");
        send(4'hB, nb);
        do_write("w mirror y", 1'b0);
        set_win(27, 28, 35, 36, 2, 1, 4, 3);
        check_frame("mirror y");
        send(4'hC, nb);
        send(4'h8, nb);
        do_write("w ccw", 1'b0);
        set_win(27, 28, 35, 36, 2, 4, 1, 3);
        check_frame("ccw");
        send(4'hC, nb);
        send(4'hA, nb);
        send(4'h6, nb);
        send(4'hD, nb);
        check("nop busy cycles", nb, 1);
        do_write("w mirx min", 1'b0);
        set_win(27, 28, 35, 36, 1, 1, 1, 1);
        check_frame("mirror x min");
        send(4'hC, nb);
        send(4'hA, nb);
        do_write("w mirror x", 1'b0);
        set_win(27, 28, 35, 36, 3, 4, 1, 2);
        check_frame("mirror x");

        // up x5 stops at y=0, right x6 stops at x=6, Max there
        send(4'hC, nb);
        send_n(4'h1, 5);
        send_n(4'h4, 6);
        send(4'h5, nb);
        do_write("w top right", 1'b0);
        load_exp();
        set_win(6, 7, 14, 15, 15, 15, 15, 15);
        check_frame("top right");

        // reset mid-WRITE at address 20
        wait_idle("pre abort");
        cmd = 4'h0; cv = 1'b1;
        @(negedge clk);
        cv = 1'b0;
        t = 0;
        while (!(iram_v1 && iram_a1 == 6'd20) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("abort reached a20", int'(iram_a1), 20);
        reset = 1'b1;
        #1;
        check("abort IRAM_valid", int'(iram_v1), 0);
        check("abort busy", int'(busy1), 1);
        check("abort IROM_rd", int'(irom_rd1), 0);
        @(negedge clk);
        reset = 1'b0;
        t = 0;
        while (!irom_rd1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("reload rd", int'(irom_rd1), 1);
        check("reload from a0", int'(irom_a1), 0);
        wait_idle("after abort");

        // second configuration: 16x4, 10-bit, origin (7,1)
        sel = 1;
        wait_idle("dut2 load");
        send(4'h5, nb);
        do_write("w2 origin", 1'b0);
        load_exp();
        set_win(23, 24, 39, 40, 552, 552, 552, 552);
        check_frame("dut2 origin");
        send_n(4'h4, 10);
        send(4'h5, nb);
        do_write("w2 right", 1'b0);
        set_win(30, 31, 46, 47, 559, 559, 559, 559);
        check_frame("dut2 right edge");

        check("write order", seq_err[0] + seq_err[1], 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
